// File: rtl/or_and_reg.sv
// OR-AND gating cell: combinational e = (a | b) & c, plus a registered,
// valid-qualified copy and a saturating count of captured samples with any bit set.
module or_and_reg #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic             in_valid,
    input  logic             clr_cnt,
    output logic [WIDTH-1:0] e,
    output logic [WIDTH-1:0] e_q,
    output logic             out_valid,
    output logic [CNT_W-1:0] hit_cnt
);

    logic hit;

    assign e   = (a | b) & c;
    assign hit = in_valid && (|e) && (hit_cnt != '1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_q       <= '0;
            out_valid <= 1'b0;
            hit_cnt   <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                e_q <= e;
            end
            // clear takes precedence over a hit on the same edge
            if (clr_cnt) begin
                hit_cnt <= '0;
            end else if (hit) begin
                hit_cnt <= hit_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_or_and_reg.sv
// Bench for or_and_reg: a 4-bit instance and a scalar instance with a 2-bit counter,
// checked against a reference model through per-instance expectation queues.
module tb_or_and_reg;

    typedef struct packed {
        logic [3:0]  eq;
        logic        ov;
        logic [15:0] cnt;
    } exp_t;

    logic        clk;
    logic        rst_n;

    logic [3:0]  a_v, b_v, c_v, e_v, e_q_v;
    logic        vld_v, clr_v, ov_v;
    logic [15:0] cnt_v;

    logic        a_s, b_s, c_s, e_s, e_q_s;
    logic        vld_s, clr_s, ov_s;
    logic [1:0]  cnt_s;

    exp_t        q_v[$];
    exp_t        q_s[$];

    logic [3:0]  m_v_eq;
    logic [15:0] m_v_cnt;
    logic        m_s_eq;
    logic [1:0]  m_s_cnt;

    int n_pass;
    int n_total;

    or_and_reg #(.WIDTH(4), .CNT_W(16)) u_vec (
        .clk(clk), .rst_n(rst_n), .a(a_v), .b(b_v), .c(c_v),
        .in_valid(vld_v), .clr_cnt(clr_v), .e(e_v), .e_q(e_q_v),
        .out_valid(ov_v), .hit_cnt(cnt_v)
    );

    or_and_reg #(.WIDTH(1), .CNT_W(2)) u_sc (
        .clk(clk), .rst_n(rst_n), .a(a_s), .b(b_s), .c(c_s),
        .in_valid(vld_s), .clr_cnt(clr_s), .e(e_s), .e_q(e_q_s),
        .out_valid(ov_s), .hit_cnt(cnt_s)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle on both instances, push model expectations, advance past the edge.
    task automatic step(input logic [3:0] va, input logic [3:0] vb, input logic [3:0] vc,
                        input logic vvld, input logic vclr,
                        input logic sa, input logic sb, input logic sc,
                        input logic svld, input logic sclr);
        logic [3:0] ev;
        logic       es;
        exp_t       xv;
        exp_t       xs;
        a_v = va; b_v = vb; c_v = vc; vld_v = vvld; clr_v = vclr;
        a_s = sa; b_s = sb; c_s = sc; vld_s = svld; clr_s = sclr;
        ev = (va | vb) & vc;
        es = (sa | sb) & sc;
        if (vvld) m_v_eq = ev;
        if (vclr) m_v_cnt = '0;
        else if (vvld && ev != 4'b0000 && m_v_cnt != 16'hFFFF) m_v_cnt = m_v_cnt + 16'd1;
        if (svld) m_s_eq = es;
        if (sclr) m_s_cnt = '0;
        else if (svld && es && m_s_cnt != 2'b11) m_s_cnt = m_s_cnt + 2'd1;
        xv.eq = m_v_eq; xv.ov = vvld; xv.cnt = m_v_cnt;
        xs.eq = {3'b000, m_s_eq}; xs.ov = svld; xs.cnt = {14'd0, m_s_cnt};
        q_v.push_back(xv);
        q_s.push_back(xs);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        a_v = 4'b1111; b_v = '0; c_v = 4'b1111; vld_v = 1'b1; clr_v = 1'b0;
        a_s = 1'b1; b_s = 1'b0; c_s = 1'b1; vld_s = 1'b1; clr_s = 1'b0;
        m_v_eq = '0; m_v_cnt = '0; m_s_eq = 1'b0; m_s_cnt = '0;
        @(posedge clk);
        #1;
        n_total++; if (e_q_v !== 4'b0000) $display("FAIL reset_e_q_v: got %h expected 0", e_q_v); else n_pass++;
        n_total++; if (ov_v !== 1'b0) $display("FAIL reset_ov_v: got %b expected 0", ov_v); else n_pass++;
        n_total++; if (cnt_v !== 16'd0) $display("FAIL reset_cnt_v: got %0d expected 0", cnt_v); else n_pass++;
        n_total++; if (e_q_s !== 1'b0) $display("FAIL reset_e_q_s: got %b expected 0", e_q_s); else n_pass++;
        n_total++; if (cnt_s !== 2'd0) $display("FAIL reset_cnt_s: got %0d expected 0", cnt_s); else n_pass++;
        n_total++; if (e_v !== 4'b1111) $display("FAIL reset_e_tracks: got %h expected f", e_v); else n_pass++;
        vld_v = 1'b0; vld_s = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_scalar_sweep;
        logic [7:0] truth;
        logic [2:0] abc;
        truth = 8'b1010_1000;
        vld_v = 1'b0; clr_v = 1'b0; vld_s = 1'b0; clr_s = 1'b0;
        for (int i = 0; i < 8; i++) begin
            abc = 3'(i);
            a_s = abc[2]; b_s = abc[1]; c_s = abc[0];
            #100;
            n_total++;
            if (e_s !== truth[i]) $display("FAIL sweep_abc%0d: got %b expected %b", i, e_s, truth[i]);
            else n_pass++;
        end
    endtask

    task automatic test_capture;
        exp_t xv, xs;
        step('0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        xv = q_v.pop_front(); xs = q_s.pop_front();
        n_total++; if (e_q_s !== 1'b1 || e_q_s !== xs.eq[0]) $display("FAIL capture_e_q: got %b expected %b", e_q_s, xs.eq[0]); else n_pass++;
        n_total++; if (ov_s !== 1'b1 || ov_s !== xs.ov) $display("FAIL capture_ov: got %b expected %b", ov_s, xs.ov); else n_pass++;
        step('0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        xv = q_v.pop_front(); xs = q_s.pop_front();
        n_total++; if (ov_s !== 1'b0 || ov_s !== xs.ov) $display("FAIL capture_ov_drop: got %b expected %b", ov_s, xs.ov); else n_pass++;
        n_total++; if (e_q_s !== 1'b1 || e_q_s !== xs.eq[0]) $display("FAIL capture_hold: got %b expected %b", e_q_s, xs.eq[0]); else n_pass++;
        n_total++; if (cnt_s !== xs.cnt[1:0]) $display("FAIL capture_cnt: got %0d expected %0d", cnt_s, xs.cnt[1:0]); else n_pass++;
    endtask

    task automatic test_saturation;
        exp_t xv, xs;
        logic [1:0] seq [5];
        seq = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        step('0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        xv = q_v.pop_front(); xs = q_s.pop_front();
        n_total++; if (cnt_s !== 2'd0) $display("FAIL sat_clear: got %0d expected 0", cnt_s); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            step('0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
            xv = q_v.pop_front(); xs = q_s.pop_front();
            n_total++;
            if (cnt_s !== seq[i] || cnt_s !== xs.cnt[1:0]) $display("FAIL sat_cnt%0d: got %0d expected %0d", i, cnt_s, seq[i]);
            else n_pass++;
        end
    endtask

    task automatic test_clear_priority;
        exp_t xv, xs;
        step('0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        xv = q_v.pop_front(); xs = q_s.pop_front();
        n_total++; if (cnt_s !== 2'd0 || cnt_s !== xs.cnt[1:0]) $display("FAIL clr_priority: got %0d expected 0", cnt_s); else n_pass++;
        n_total++; if (e_q_s !== xs.eq[0]) $display("FAIL clr_capture: got %b expected %b", e_q_s, xs.eq[0]); else n_pass++;
    endtask

    task automatic test_vector;
        exp_t xv, xs;
        step('0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        xv = q_v.pop_front(); xs = q_s.pop_front();
        n_total++; if (cnt_v !== 16'd0) $display("FAIL vec_clear: got %0d expected 0", cnt_v); else n_pass++;
        a_v = 4'b0101; b_v = 4'b0011; c_v = 4'b1110;
        #1;
        n_total++; if (e_v !== 4'b0110) $display("FAIL vec_e: got %b expected 0110", e_v); else n_pass++;
        step(4'b0101, 4'b0011, 4'b1110, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        xv = q_v.pop_front(); xs = q_s.pop_front();
        n_total++; if (e_q_v !== 4'b0110 || e_q_v !== xv.eq) $display("FAIL vec_e_q: got %b expected %b", e_q_v, xv.eq); else n_pass++;
        n_total++; if (cnt_v !== 16'd1 || cnt_v !== xv.cnt) $display("FAIL vec_cnt: got %0d expected 1", cnt_v); else n_pass++;
    endtask

    task automatic test_async_reset;
        exp_t xv, xs;
        step('0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        xv = q_v.pop_front(); xs = q_s.pop_front();
        for (int i = 0; i < 5; i++) begin
            step(4'b0001, 4'b0000, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            xv = q_v.pop_front(); xs = q_s.pop_front();
        end
        n_total++; if (cnt_v !== 16'd5 || cnt_v !== xv.cnt) $display("FAIL arst_pre_cnt: got %0d expected 5", cnt_v); else n_pass++;
        n_total++; if (e_q_v !== 4'b0001) $display("FAIL arst_pre_e_q: got %b expected 0001", e_q_v); else n_pass++;
        #2;
        a_v = 4'b1000; b_v = 4'b0000; c_v = 4'b1000;
        rst_n = 1'b0;
        #1;
        n_total++; if (e_q_v !== 4'b0000) $display("FAIL arst_e_q: got %b expected 0000", e_q_v); else n_pass++;
        n_total++; if (ov_v !== 1'b0) $display("FAIL arst_ov: got %b expected 0", ov_v); else n_pass++;
        n_total++; if (cnt_v !== 16'd0) $display("FAIL arst_cnt: got %0d expected 0", cnt_v); else n_pass++;
        n_total++; if (e_v !== 4'b1000) $display("FAIL arst_e_tracks: got %b expected 1000", e_v); else n_pass++;
        m_v_eq = '0; m_v_cnt = '0; m_s_eq = 1'b0; m_s_cnt = '0;
        q_v.delete(); q_s.delete();
        vld_v = 1'b0; vld_s = 1'b0;
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_total++; if (ov_v !== 1'b0) $display("FAIL arst_no_pulse: got %b expected 0", ov_v); else n_pass++;
        n_total++; if (e_q_v !== 4'b0000) $display("FAIL arst_discard: got %b expected 0000", e_q_v); else n_pass++;
    endtask

    task automatic test_back_to_back;
        exp_t xv, xs;
        logic [3:0] ra, rb, rc;
        for (int i = 0; i < 6; i++) begin
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            rc = 4'($urandom_range(1, 15));
            step(ra, rb, rc, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            xv = q_v.pop_front(); xs = q_s.pop_front();
            n_total++; if (e_q_v !== xv.eq) $display("FAIL b2b_e_q%0d: got %b expected %b", i, e_q_v, xv.eq); else n_pass++;
            n_total++; if (ov_v !== 1'b1) $display("FAIL b2b_ov%0d: got %b expected 1", i, ov_v); else n_pass++;
            n_total++; if (cnt_v !== xv.cnt) $display("FAIL b2b_cnt%0d: got %0d expected %0d", i, cnt_v, xv.cnt); else n_pass++;
        end
        step('0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        xv = q_v.pop_front(); xs = q_s.pop_front();
        n_total++; if (ov_v !== 1'b0 || e_q_v !== xv.eq) $display("FAIL b2b_idle: got ov=%b e_q=%b expected ov=0 e_q=%b", ov_v, e_q_v, xv.eq); else n_pass++;
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        test_reset();
        @(posedge clk);
        #1;
        test_scalar_sweep();
        test_capture();
        test_saturation();
        test_clear_priority();
        test_vector();
        test_async_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
